// File: rtl/wave_select_sync.sv
// Glitch-free DAC waveform selector: channel changes wait for the next phase wrap, or for a timeout.
// Optional linear crossfade between channels when WAVE_SELECT_CROSSFADE_EN is defined.
module wave_select_sync #(
  parameter int WIDTH       = 16,
  parameter int NUM_CH      = 4,
  parameter int SEL_W       = 2,
  parameter int DEFAULT_SEL = 1,
  parameter int TIMEOUT     = 4096,
  parameter int FADE_LOG2   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_en,
  input  logic                    phase_wrap,
  input  logic [NUM_CH*WIDTH-1:0] ch_data,
  input  logic [SEL_W-1:0]        sel_req,
  input  logic                    sel_load,
  output logic [WIDTH-1:0]        sig_out,
  output logic [SEL_W-1:0]        active_sel,
  output logic                    busy,
  output logic                    sel_err
);

  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [SEL_W:0] NCH = (SEL_W+1)'(NUM_CH);
  localparam logic [TCNT_W-1:0] TLAST = TCNT_W'(TIMEOUT - 1);

  if (NUM_CH < 2 || TIMEOUT < 1 || FADE_LOG2 < 1 || DEFAULT_SEL >= NUM_CH) begin : g_bad_cfg
    $error("wave_select_sync: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1
`ifdef WAVE_SELECT_CROSSFADE_EN
    , FADE  = 2'd2
`endif
  } state_t;

  state_t              state, state_n;
  logic [SEL_W-1:0]    pend_sel, pend_n, active_n;
  logic [TCNT_W-1:0]   tcnt, tcnt_n;
  logic [WIDTH-1:0]    out_n;
  logic                err_n, req_ok, fire;

  function automatic logic [WIDTH-1:0] pick(input logic [NUM_CH*WIDTH-1:0] d,
                                            input logic [SEL_W-1:0] s);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (s == SEL_W'(i)) v = d[i*WIDTH +: WIDTH];
    end
    return v;
  endfunction

`ifdef WAVE_SELECT_CROSSFADE_EN
  localparam int AW = WIDTH + FADE_LOG2 + 1;
  localparam logic [FADE_LOG2:0] WGT = (FADE_LOG2+1)'(1 << FADE_LOG2);
  localparam logic [FADE_LOG2-1:0] KLAST = '1;

  logic [SEL_W-1:0]     old_sel, old_n;
  logic [FADE_LOG2-1:0] k, k_n;
  logic                 pend_vld, pv_n;
  logic [AW-1:0]        acc;

  // Weighted sum cannot overflow AW bits: the weights always add up to 2^F.
  always_comb begin
    acc = AW'(pick(ch_data, old_sel)) * AW'(WGT - {1'b0, k})
        + AW'(pick(ch_data, active_sel)) * AW'(k);
  end
`endif

  always_comb begin
    req_ok   = sel_load && ({1'b0, sel_req} < NCH);
    fire     = (state == PENDING) && sample_en && (phase_wrap || tcnt == TLAST);
    state_n  = state;
    pend_n   = pend_sel;
    tcnt_n   = tcnt;
    active_n = active_sel;
    out_n    = sig_out;
    err_n    = sel_load && !req_ok;
`ifdef WAVE_SELECT_CROSSFADE_EN
    old_n    = old_sel;
    k_n      = k;
    pv_n     = pend_vld;
`endif
    case (state)
      IDLE: begin
        if (req_ok && sel_req != active_sel) begin
          state_n = PENDING;
          pend_n  = sel_req;
          tcnt_n  = '0;
        end
      end
      PENDING: begin
        if (fire) begin
          active_n = pend_sel;
`ifdef WAVE_SELECT_CROSSFADE_EN
          state_n = FADE;
          old_n   = active_sel;
          k_n     = '0;
          pv_n    = req_ok && sel_req != pend_sel;
          if (req_ok) pend_n = sel_req;
`else
          // A same-cycle request is judged against the channel just switched to.
          if (req_ok && sel_req != pend_sel) begin
            pend_n = sel_req;
            tcnt_n = '0;
          end else begin
            state_n = IDLE;
          end
`endif
        end else begin
          if (sample_en) tcnt_n = tcnt + 1'b1;
          if (req_ok) begin
            if (sel_req == active_sel) state_n = IDLE;
            else pend_n = sel_req;
          end
        end
      end
`ifdef WAVE_SELECT_CROSSFADE_EN
      FADE: begin
        if (req_ok) begin
          pend_n = sel_req;
          pv_n   = 1'b1;
        end
        if (sample_en) begin
          if (k == KLAST) begin
            if (pv_n && pend_n != active_sel) begin
              state_n = PENDING;
              tcnt_n  = '0;
            end else begin
              state_n = IDLE;
            end
            pv_n = 1'b0;
          end else begin
            k_n = k + 1'b1;
          end
        end
      end
`endif
      default: state_n = IDLE;
    endcase

    if (sample_en) begin
`ifdef WAVE_SELECT_CROSSFADE_EN
      if (state == FADE) out_n = acc[FADE_LOG2 +: WIDTH];
      else out_n = pick(ch_data, active_sel);
`else
      out_n = pick(ch_data, fire ? pend_sel : active_sel);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pend_sel   <= SEL_W'(DEFAULT_SEL);
      tcnt       <= '0;
      active_sel <= SEL_W'(DEFAULT_SEL);
      sig_out    <= '0;
      busy       <= 1'b0;
      sel_err    <= 1'b0;
`ifdef WAVE_SELECT_CROSSFADE_EN
      old_sel    <= SEL_W'(DEFAULT_SEL);
      k          <= '0;
      pend_vld   <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      pend_sel   <= pend_n;
      tcnt       <= tcnt_n;
      active_sel <= active_n;
      sig_out    <= out_n;
      busy       <= (state_n != IDLE);
      sel_err    <= err_n;
`ifdef WAVE_SELECT_CROSSFADE_EN
      old_sel    <= old_n;
      k          <= k_n;
      pend_vld   <= pv_n;
`endif
    end
  end

endmodule

// File: tb/tb_wave_select_sync.sv
// Directed bench for wave_select_sync (hard-cut build): deferred switch, timeout, request handling, reset.
module tb_wave_select_sync;

  localparam int WIDTH = 16;
  localparam int NUM_CH = 4;
  localparam int SEL_W = 3;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    sample_en = 1'b0;
  logic                    phase_wrap = 1'b0;
  logic [NUM_CH*WIDTH-1:0] ch_data;
  logic [SEL_W-1:0]        sel_req = '0;
  logic                    sel_load = 1'b0;
  logic [WIDTH-1:0]        sig_out;
  logic [SEL_W-1:0]        active_sel;
  logic                    busy;
  logic                    sel_err;

  int n_checks = 0;
  int n_fail = 0;

  wave_select_sync #(
    .WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W), .DEFAULT_SEL(1),
    .TIMEOUT(8), .FADE_LOG2(2)
  ) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .phase_wrap(phase_wrap),
    .ch_data(ch_data), .sel_req(sel_req), .sel_load(sel_load),
    .sig_out(sig_out), .active_sel(active_sel), .busy(busy), .sel_err(sel_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one clock of inputs at the falling edge, then settle just past the rising edge.
  task automatic cycle(input logic se, input logic pw, input logic ld, input logic [SEL_W-1:0] req);
    @(negedge clk);
    sample_en  = se;
    phase_wrap = pw;
    sel_load   = ld;
    sel_req    = req;
    @(posedge clk);
    #1;
    sample_en  = 1'b0;
    phase_wrap = 1'b0;
    sel_load   = 1'b0;
  endtask

  task automatic samples(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic expect_out(input string tag, input logic [15:0] s, input logic [2:0] a, input logic b);
    check({tag, ".sig_out"}, 32'(sig_out), 32'(s));
    check({tag, ".active_sel"}, 32'(active_sel), 32'(a));
    check({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  initial begin
    ch_data = {16'h5555, 16'hAAAA, 16'h1234, 16'h0F0F};

    reset = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    expect_out("reset", 16'h0000, 3'd1, 1'b0);
    check("reset.sel_err", 32'(sel_err), 32'd0);
    reset = 1'b0;

    samples(1);
    expect_out("first_sample", 16'h1234, 3'd1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    check("hold_no_strobe", 32'(sig_out), 32'h1234);

    // deferred switch to ch2 on phase wrap
    cycle(1'b0, 1'b0, 1'b1, 3'd2);
    expect_out("load2", 16'h1234, 3'd1, 1'b1);
    samples(5);
    expect_out("no_wrap5", 16'h1234, 3'd1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, '0);
    expect_out("wrap_unqualified", 16'h1234, 3'd1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, '0);
    expect_out("wrap_switch", 16'hAAAA, 3'd2, 1'b0);

    // timeout: switch lands exactly on the 8th strobe
    cycle(1'b0, 1'b0, 1'b1, 3'd3);
    samples(7);
    expect_out("timeout_7", 16'hAAAA, 3'd2, 1'b1);
    samples(1);
    expect_out("timeout_8", 16'h5555, 3'd3, 1'b0);

    // back to ch1 via wrap
    cycle(1'b0, 1'b0, 1'b1, 3'd1);
    cycle(1'b1, 1'b1, 1'b0, '0);
    expect_out("back_to1", 16'h1234, 3'd1, 1'b0);

    // cancel by requesting the active channel
    cycle(1'b0, 1'b0, 1'b1, 3'd3);
    check("cancel.busy_up", 32'(busy), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 3'd1);
    check("cancel.busy_down", 32'(busy), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    expect_out("cancel.no_switch", 16'h1234, 3'd1, 1'b0);

    // same-channel request in IDLE is ignored
    cycle(1'b0, 1'b0, 1'b1, 3'd1);
    check("same_req.busy", 32'(busy), 32'd0);

    // out-of-range request in IDLE
    cycle(1'b0, 1'b0, 1'b1, 3'd5);
    check("err_idle.pulse", 32'(sel_err), 32'd1);
    check("err_idle.busy", 32'(busy), 32'd0);
    check("err_idle.active", 32'(active_sel), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, '0);
    check("err_idle.one_cycle", 32'(sel_err), 32'd0);

    // out-of-range request in PENDING keeps the pending channel
    cycle(1'b0, 1'b0, 1'b1, 3'd2);
    cycle(1'b0, 1'b0, 1'b1, 3'd4);
    check("err_pend.pulse", 32'(sel_err), 32'd1);
    check("err_pend.busy", 32'(busy), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, '0);
    expect_out("err_pend.switch", 16'hAAAA, 3'd2, 1'b0);

    // replacing pend_sel does not restart the timeout
    cycle(1'b0, 1'b0, 1'b1, 3'd3);
    samples(4);
    cycle(1'b0, 1'b0, 1'b1, 3'd0);
    samples(3);
    expect_out("replace_7", 16'hAAAA, 3'd2, 1'b1);
    samples(1);
    expect_out("replace_8", 16'h0F0F, 3'd0, 1'b0);

    // load coinciding with a switch: switch uses old pend_sel, new request goes pending
    cycle(1'b0, 1'b0, 1'b1, 3'd1);
    cycle(1'b1, 1'b1, 1'b1, 3'd2);
    expect_out("coincide.switch", 16'h1234, 3'd1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, '0);
    expect_out("coincide.second", 16'hAAAA, 3'd2, 1'b0);

    // coinciding request equal to the new channel leaves the block idle
    cycle(1'b0, 1'b0, 1'b1, 3'd0);
    cycle(1'b1, 1'b1, 1'b1, 3'd0);
    expect_out("coincide.same", 16'h0F0F, 3'd0, 1'b0);

    // reset while pending
    cycle(1'b0, 1'b0, 1'b1, 3'd3);
    samples(2);
    reset = 1'b1;
    cycle(1'b1, 1'b1, 1'b0, '0);
    expect_out("reset_pend", 16'h0000, 3'd1, 1'b0);
    reset = 1'b0;
    samples(8);
    expect_out("after_reset", 16'h1234, 3'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
